// File: rtl/core_fpu_pkg.sv
// ---------------------------------------------------------------------------
// core_fpu_pkg
// Shared definitions for the FP issue controller:
//   - op-code localparams (4-bit, as produced by the decode encoder)
//   - slot_t: one writeback reservation entry
//   - op classification helpers used by issue logic (latency, operand use,
//     destination register file, divider occupancy)
// ---------------------------------------------------------------------------
package core_fpu_pkg;

  localparam logic [3:0] OP_NONE   = 4'd0;
  localparam logic [3:0] OP_FADD   = 4'd1;
  localparam logic [3:0] OP_FSUB   = 4'd2;
  localparam logic [3:0] OP_FMUL   = 4'd3;
  localparam logic [3:0] OP_FDIV   = 4'd4;
  localparam logic [3:0] OP_FSQRT  = 4'd5;
  localparam logic [3:0] OP_FSGNJX = 4'd6;
  localparam logic [3:0] OP_FEQ    = 4'd7;
  localparam logic [3:0] OP_FLT    = 4'd8;
  localparam logic [3:0] OP_FLE    = 4'd9;
  localparam logic [3:0] OP_FMVSX  = 4'd10;
  localparam logic [3:0] OP_FCVTSW = 4'd11;
  localparam logic [3:0] OP_FCVTWS = 4'd12;

  // One writeback reservation: is_int selects X (1) or F (0) register file.
  typedef struct packed {
    logic       valid;
    logic       is_int;
    logic [4:0] rg;
    logic [3:0] op;
  } slot_t;

  // Unassigned encodings behave exactly like NONE.
  function automatic logic [3:0] op_norm(input logic [3:0] op);
    return (op > OP_FCVTWS) ? OP_NONE : op;
  endfunction

  // Cycles from accept to writeback. Single-cycle ops are fixed at 1.
  function automatic int op_lat(input logic [3:0] op, input int lat_add,
                                input int lat_mul, input int lat_div,
                                input int lat_cvt);
    case (op)
      OP_FADD, OP_FSUB:     return lat_add;
      OP_FMUL:              return lat_mul;
      OP_FDIV, OP_FSQRT:    return lat_div;
      OP_FCVTSW, OP_FCVTWS: return lat_cvt;
      default:              return 1;
    endcase
  endfunction

  function automatic logic op_int_dst(input logic [3:0] op);
    return (op == OP_FEQ) || (op == OP_FLT) || (op == OP_FLE) ||
           (op == OP_FCVTWS);
  endfunction

  function automatic logic op_uses_frs2(input logic [3:0] op);
    return ((op >= OP_FADD) && (op <= OP_FDIV)) ||
           ((op >= OP_FSGNJX) && (op <= OP_FLE));
  endfunction

  // FSQRT and FCVTWS read only FRS1; FMVSX/FCVTSW read an integer source.
  function automatic logic op_uses_frs1(input logic [3:0] op);
    return op_uses_frs2(op) || (op == OP_FSQRT) || (op == OP_FCVTWS);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_FDIV) || (op == OP_FSQRT);
  endfunction

endpackage

// File: rtl/core_fpu_wbres.sv
// ---------------------------------------------------------------------------
// core_fpu_wbres
// Writeback-port reservation shift register. slot[k] describes the result
// that will be on the shared FP writeback port k cycles from now; the array
// advances one entry every clock.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   ins_en          insert ins_slot this edge
//   ins_lat         latency L of the inserted op; lands in slot[L-1]
//   ins_slot        entry to insert
//   chk_lat         latency to test for a port collision
//   conflict        registered slot[chk_lat] is valid (never for MAX_LAT)
//   slot0           entry writing back this cycle
//   any_valid       at least one entry is valid
// ---------------------------------------------------------------------------
module core_fpu_wbres
  import core_fpu_pkg::*;
#(
  parameter int MAX_LAT = 16,
  localparam int IW = $clog2(MAX_LAT + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ins_en,
  input  logic [IW-1:0] ins_lat,
  input  slot_t         ins_slot,
  input  logic [IW-1:0] chk_lat,
  output logic          conflict,
  output slot_t         slot0,
  output logic          any_valid
);

  slot_t [MAX_LAT-1:0] slot;
  slot_t [MAX_LAT-1:0] slot_nxt;
  logic  [MAX_LAT-1:0] vvec;

  // Shift toward slot[0]; the top entry empties. An op of latency L is
  // placed in slot[L-1] of the shifted array, so the collision it must avoid
  // is the current slot[L], which is exactly what moves into slot[L-1].
  always_comb begin
    slot_nxt = slot >> $bits(slot_t);
    for (int k = 0; k < MAX_LAT; k++)
      if (ins_en && (ins_lat == IW'(k + 1))) slot_nxt[k] = ins_slot;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) slot <= '0;
    else     slot <= slot_nxt;
  end

  // chk_lat == MAX_LAT matches no entry, so the deepest latency never stalls.
  always_comb begin
    conflict = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      vvec[k] = slot[k].valid;
      if (chk_lat == IW'(k)) conflict = slot[k].valid;
    end
  end

  assign slot0     = slot[0];
  assign any_valid = |vvec;

endmodule

// File: rtl/core_fpu_issue.sv
// ---------------------------------------------------------------------------
// core_fpu_issue
// FP issue controller. Accepts one decoded FP op per cycle when there is no
// RAW/WAW hazard against the pending-register masks, the shared writeback
// port is free at the op's completion cycle, and (for FDIV/FSQRT) the
// non-pipelined divider is idle. Issues a start strobe to the units and
// replays the result tag on the writeback stream.
// Ports:
//   CLK, RST                    clock, asynchronous active-high reset
//   ISSUE_VALID / ISSUE_READY   issue handshake (READY is combinational and
//                               independent of VALID)
//   OP, FRD/FRS1/FRS2/RD_NUM    decoded op and register numbers
//   FU_START, FU_OP             unit start strobe and op
//   WB_VALID/INT/REG/OP         writeback tag for the result completing now
//   FP_BUSY, X_BUSY             FP / integer pending-register masks
//   DIV_BUSY                    divide/sqrt unit occupied
//   IDLE                        no result in flight
// Every latency parameter must lie in 1..MAX_LAT.
// ---------------------------------------------------------------------------
module core_fpu_issue
  import core_fpu_pkg::*;
#(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 10,
  parameter int LAT_CVT = 2,
  parameter int MAX_LAT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ISSUE_VALID,
  output logic        ISSUE_READY,
  input  logic [3:0]  OP,
  input  logic [4:0]  FRD_NUM,
  input  logic [4:0]  FRS1_NUM,
  input  logic [4:0]  FRS2_NUM,
  input  logic [4:0]  RD_NUM,
  output logic        FU_START,
  output logic [3:0]  FU_OP,
  output logic        WB_VALID,
  output logic        WB_INT,
  output logic [4:0]  WB_REG,
  output logic [3:0]  WB_OP,
  output logic [31:0] FP_BUSY,
  output logic [31:0] X_BUSY,
  output logic        DIV_BUSY,
  output logic        IDLE
);

  localparam int IW = $clog2(MAX_LAT + 1);

  logic [3:0]    op_n;
  logic [IW-1:0] lat;
  logic          is_int;
  logic          is_op;
  logic          raw_haz;
  logic          waw_haz;
  logic          div_haz;
  logic          wb_conf;
  logic          accept;
  logic          any_valid;
  slot_t         ins;
  slot_t         slot0;
  logic [31:0]   fp_set, fp_clr, x_set, x_clr;

  // ---- decode of the presented op ----
  always_comb begin
    op_n   = op_norm(OP);
    lat    = IW'(op_lat(op_n, LAT_ADD, LAT_MUL, LAT_DIV, LAT_CVT));
    is_int = op_int_dst(op_n);
    is_op  = (op_n != OP_NONE);

    ins        = '0;
    ins.valid  = 1'b1;
    ins.is_int = is_int;
    ins.rg     = is_int ? RD_NUM : FRD_NUM;
    ins.op     = op_n;
  end

  core_fpu_wbres #(.MAX_LAT(MAX_LAT)) u_wbres (
    .CLK       (CLK),
    .RST       (RST),
    .ins_en    (accept),
    .ins_lat   (lat),
    .ins_slot  (ins),
    .chk_lat   (lat),
    .conflict  (wb_conf),
    .slot0     (slot0),
    .any_valid (any_valid)
  );

  // ---- hazard checks: registered masks only, no writeback bypass ----
  always_comb begin
    raw_haz = (op_uses_frs1(op_n) && FP_BUSY[FRS1_NUM]) ||
              (op_uses_frs2(op_n) && FP_BUSY[FRS2_NUM]);
    waw_haz = is_op && (is_int ? X_BUSY[RD_NUM] : FP_BUSY[FRD_NUM]);
    div_haz = op_is_div(op_n) && DIV_BUSY;
    // NONE never stalls, whatever the reservation state.
    ISSUE_READY = !(raw_haz || waw_haz || div_haz || (is_op && wb_conf));
    accept      = ISSUE_VALID && ISSUE_READY && is_op;
  end

  assign FU_START = accept;
  assign FU_OP    = OP;

  // ---- pending masks ----
  // x0 is hardwired zero in the integer file, so it is never marked pending.
  always_comb begin
    fp_set = '0;
    x_set  = '0;
    fp_clr = '0;
    x_clr  = '0;
    if (accept && !is_int)                      fp_set[FRD_NUM] = 1'b1;
    if (accept && is_int && (RD_NUM != 5'd0))   x_set[RD_NUM]   = 1'b1;
    if (slot0.valid && !slot0.is_int)           fp_clr[slot0.rg] = 1'b1;
    if (slot0.valid && slot0.is_int)            x_clr[slot0.rg]  = 1'b1;
  end

  // A bit is never set and cleared in the same cycle: WAW stalls the setter
  // until the writeback cycle has passed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FP_BUSY  <= '0;
      X_BUSY   <= '0;
      DIV_BUSY <= 1'b0;
    end else begin
      FP_BUSY  <= (FP_BUSY & ~fp_clr) | fp_set;
      X_BUSY   <= (X_BUSY & ~x_clr) | x_set;
      DIV_BUSY <= (DIV_BUSY && !(slot0.valid && op_is_div(slot0.op))) ||
                  (accept && op_is_div(op_n));
    end
  end

  // ---- writeback tag stream ----
  assign WB_VALID = slot0.valid;
  assign WB_INT   = slot0.is_int;
  assign WB_REG   = slot0.rg;
  assign WB_OP    = slot0.op;
  assign IDLE     = !any_valid;

endmodule

// File: doc/core_fpu_issue.md
# core_fpu_issue

FP issue controller between `core_decode` and the floating-point units. It accepts one decoded FP operation per cycle and checks RAW/WAW hazards against FP and integer pending-register scoreboards. It reserves a slot on the single shared FP writeback port so that no two results complete in the same cycle, and serialises the non-pipelined divide/sqrt unit. It drives the unit start strobe and the writeback tag stream.

## Interface
- `LAT_ADD`, 2: latency of FADD/FSUB.
- `LAT_MUL`, 2: latency of FMUL.
- `LAT_DIV`, 10: latency of FDIV and FSQRT.
- `LAT_CVT`, 2: latency of FCVTSW/FCVTWS.
- `MAX_LAT`, 16: writeback reservation depth. Every latency must lie in 1..MAX_LAT.
- `CLK` in 1: the single clock.
- `RST` in 1: asynchronous, active-high reset.
- `ISSUE_VALID` in 1: a decoded op is presented.
- `ISSUE_READY` out 1: combinational; the op is accepted this cycle.
- `OP` in 4: op code from the shared package.
- `FRD_NUM`, `FRS1_NUM`, `FRS2_NUM`, `RD_NUM` in 5 each: register numbers as decoded.
- `FU_START` out 1: combinational; equals the issue handshake for any op other than NONE.
- `FU_OP` out 4: combinational copy of `OP`.
- `WB_VALID` out 1: a result writes back this cycle.
- `WB_INT` out 1: 1 means the destination is integer `RD`; 0 means FP `FRD`.
- `WB_REG` out 5: destination register number.
- `WB_OP` out 4: op code of the result.
- `FP_BUSY` out 32: FP pending mask.
- `X_BUSY` out 32: integer pending mask, read by integer issue.
- `DIV_BUSY` out 1: the divide/sqrt unit is occupied.
- `IDLE` out 1: no reservation slot is valid.

## Operation
- Op codes: NONE=0, FADD=1, FSUB=2, FMUL=3, FDIV=4, FSQRT=5, FSGNJX=6, FEQ=7, FLT=8, FLE=9, FMVSX=10, FCVTSW=11, FCVTWS=12.
  - Codes 13–15 are treated as NONE.
  - NONE is always accepted and has no effect.
- Latencies:
  - FSGNJX, FEQ, FLT, FLE, FMVSX: 1.
  - The remaining ops use their parameter.
- Operand classes:
  - FP sources FRS1+FRS2: ops 1–4, 6–9.
  - FP source FRS1 only: FSQRT and FCVTWS.
  - No FP source: FMVSX and FCVTSW.
  - Integer destination `RD`: FEQ, FLT, FLE, FCVTWS.
  - FP destination `FRD`: all other ops.
- Reservation array: `slot[0..MAX_LAT-1]`, each entry {valid, int, reg, op}. Every edge performs `slot[k] <= slot[k+1]`, with `slot[MAX_LAT-1]` cleared.
- An accepted op of latency L is written into `slot[L-1]` after the shift.
- `WB_*` outputs are driven directly from `slot[0]`.
- `ISSUE_READY` is 1 unless any of the following holds:
  - a valid FP source has its `FP_BUSY` bit set;
  - the destination's bit is set in its mask (WAW);
  - the registered `slot[L].valid` is 1 (for L=MAX_LAT there is no conflict);
  - the op is FDIV/FSQRT and `DIV_BUSY` is set.
- On accept, set the destination's pending bit.
  - For an integer destination, `RD`=0 never sets `X_BUSY[0]`.
  - FP f0 is a real register.
- Pending bits and `DIV_BUSY` clear at the edge ending the cycle where `slot[0]` holds the matching result.
  - Within the writeback cycle they are still set, so hazard checks use only registered state (no bypass).
- Set and clear of the same bit in one cycle cannot occur, because WAW stalls.

## Timing
- Reset values (asynchronous, immediate):
  - all slots invalid;
  - `FP_BUSY`=0, `X_BUSY`=0, `DIV_BUSY`=0;
  - `WB_VALID`=0, `WB_INT`=0, `WB_REG`=0, `WB_OP`=0;
  - `IDLE`=1.
  - Hence `ISSUE_READY`=1.
- An op accepted in cycle t has `WB_VALID`=1 in cycle t+L, for exactly one cycle.
- The earliest accept of a dependent op is cycle t+L+1.
- The earliest accept of a second FDIV/FSQRT is cycle t+LAT_DIV+1.
- `RST` mid-operation discards all in-flight results; no `WB_VALID` follows.
- `ISSUE_READY` does not depend on `ISSUE_VALID`.

## Structure
- Package `core_fpu_pkg` holds:
  - the op-code localparams;
  - the slot struct typedef;
  - the functions `op_lat`, `op_int_dst`, `op_uses_frs1`, `op_uses_frs2`.
- The `core_decode` one-hot flags are encoded to `OP` upstream.
- Sub-module `core_fpu_wbres`: the reservation shift register. It takes insert index/tag and outputs conflict status and `slot[0]`.

## Test plan
- Reset: hold `RST`, then release. Expect `FP_BUSY`=0, `X_BUSY`=0, `WB_VALID`=0, `ISSUE_READY`=1, `IDLE`=1.
- FADD f3,f1,f2 accepted in cycle 0:
  - `FU_START`=1 in cycle 0;
  - `FP_BUSY[3]`=1 in cycles 1–2;
  - `WB_VALID`=1, `WB_REG`=3, `WB_INT`=0 in cycle 2;
  - `FP_BUSY[3]`=0 in cycle 3.
- RAW: FMUL f4 in cycle 0, then FADD f5,f4,f1 offered from cycle 1. Expect `ISSUE_READY`=0 in cycles 1–2, accepted in cycle 3, writeback in cycle 5.
- Writeback conflict: FDIV f6 in cycle 0, FADD f7 offered in cycle 8. Expect `ISSUE_READY`=0 in cycle 8, accepted in cycle 9. Writebacks: f6 in cycle 10, f7 in cycle 11.
- Divider and x0:
  - FDIV then FSQRT back-to-back: FSQRT accepted in cycle 11.
  - FEQ with `RD`=0: `WB_VALID`=1 in cycle 1, `X_BUSY` stays 0.
- Asynchronous reset: assert `RST` in cycle 5 of an FDIV, between clock edges. All masks and `DIV_BUSY` go to 0 before the next edge, and no `WB_VALID` occurs afterwards.
